// File: rtl/trigger_capture.sv
`default_nettype none
// ============================================================================
// Module      : trigger_capture
// Description : Oscilloscope frame-RAM writer. Samples into a circular buffer,
//               detects a level/slope trigger and holds one pre/post frame.
// Revision    : 1.0 - initial release
// ============================================================================
module trigger_capture #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 9,
    parameter int PRE_TRIG = 100,
    parameter int AUTO_TO  = 4095
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    input  logic              sample_en,
    input  logic              sample_type,
    input  logic              arm,
    input  logic              trig_slope,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [DATA_W-1:0] adc_db,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_ready,
    input  logic              frame_ack,
    output logic [ADDR_W-1:0] start_addr,
    output logic              trig_forced,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_WAIT = 3'd2,
        S_POST = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam int                c_TO_W       = (AUTO_TO > 1) ? $clog2(AUTO_TO + 1) : 1;
    localparam logic [ADDR_W-1:0] c_LEN_SINGLE = ADDR_W'(200);
    localparam logic [ADDR_W-1:0] c_LEN_DOUBLE = ADDR_W'(400);
    localparam logic [ADDR_W-1:0] c_ONE        = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_PRE        = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] c_PRE_LAST   = ADDR_W'((PRE_TRIG > 0) ? PRE_TRIG - 1 : 0);
    localparam logic [c_TO_W-1:0] c_TO_LAST    = c_TO_W'((AUTO_TO > 0) ? AUTO_TO - 1 : 0);
    localparam logic [c_TO_W-1:0] c_TO_ONE     = c_TO_W'(1);
    localparam logic              c_TO_EN      = (AUTO_TO != 0);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_len;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_pre_cnt;
    logic [ADDR_W-1:0]   r_post_cnt;
    logic [ADDR_W-1:0]   r_trig_addr;
    logic [c_TO_W-1:0]   r_to_cnt;
    logic [DATA_W-1:0]   r_prev;
    logic                r_prev_valid;
    logic                r_forced;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [DATA_W-1:0]   r_wr_data;
    logic                r_frame_ready;
    logic [ADDR_W-1:0]   r_start_addr;
    logic                r_trig_forced;

    logic                w_strobe;
    logic                w_cross;
    logic                w_real_trig;
    logic                w_timeout;
    logic [ADDR_W-1:0]   w_ptr_next;
    logic [ADDR_W-1:0]   w_post_next;
    logic [ADDR_W-1:0]   w_start;
    logic                w_hold;

    always_comb begin
        w_strobe    = sample_en && ((r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST));
        w_cross     = trig_slope ? ((r_prev < trig_level) && (adc_db >= trig_level))
                                 : ((r_prev > trig_level) && (adc_db <= trig_level));
        w_real_trig = w_strobe && (r_state == S_WAIT) && r_prev_valid && w_cross;
        w_timeout   = c_TO_EN && w_strobe && (r_state == S_WAIT) && (r_to_cnt == c_TO_LAST);
        w_ptr_next  = (r_wr_ptr == r_len - c_ONE) ? '0 : r_wr_ptr + c_ONE;
        w_post_next = r_post_cnt + c_ONE;
        // Oldest sample sits PRE_TRIG behind the trigger, folded back into [0, L).
        w_start     = (r_trig_addr < c_PRE) ? (r_trig_addr + r_len - c_PRE)
                                            : (r_trig_addr - c_PRE);
        w_hold      = (r_state == S_DONE) && !frame_ack;

        w_next = r_state;
        case (r_state)
            S_IDLE: if (arm) w_next = S_PRE;
            S_PRE:  if (w_strobe && (r_pre_cnt == c_PRE_LAST)) w_next = S_WAIT;
            S_WAIT: if (w_real_trig || w_timeout) w_next = S_POST;
            S_POST: if (w_strobe && (w_post_next == r_len - c_PRE)) w_next = S_DONE;
            S_DONE: if (frame_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_len         <= '0;
            r_wr_ptr      <= '0;
            r_pre_cnt     <= '0;
            r_post_cnt    <= '0;
            r_trig_addr   <= '0;
            r_to_cnt      <= '0;
            r_prev        <= '0;
            r_prev_valid  <= 1'b0;
            r_forced      <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_frame_ready <= 1'b0;
            r_start_addr  <= '0;
            r_trig_forced <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr_en <= w_strobe;
            if (w_strobe) begin
                r_wr_addr    <= r_wr_ptr;
                r_wr_data    <= adc_db;
                r_wr_ptr     <= w_ptr_next;
                r_prev       <= adc_db;
                r_prev_valid <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        r_len        <= sample_type ? c_LEN_DOUBLE : c_LEN_SINGLE;
                        r_wr_ptr     <= '0;
                        r_pre_cnt    <= '0;
                        r_post_cnt   <= '0;
                        r_to_cnt     <= '0;
                        r_prev_valid <= 1'b0;
                        r_forced     <= 1'b0;
                    end
                end
                S_PRE: if (w_strobe) r_pre_cnt <= r_pre_cnt + c_ONE;
                S_WAIT: begin
                    if (w_strobe) r_to_cnt <= r_to_cnt + c_TO_ONE;
                    // A genuine crossing on the timeout strobe is not reported as forced.
                    if (w_real_trig || w_timeout) begin
                        r_trig_addr <= r_wr_ptr;
                        r_post_cnt  <= c_ONE;
                        r_forced    <= !w_real_trig;
                    end
                end
                S_POST: if (w_strobe) r_post_cnt <= w_post_next;
                default: ;
            endcase
            r_frame_ready <= w_hold;
            r_start_addr  <= w_hold ? w_start : '0;
            r_trig_forced <= w_hold ? r_forced : 1'b0;
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign frame_ready = r_frame_ready;
    assign start_addr  = r_start_addr;
    assign trig_forced = r_trig_forced;
    assign state       = r_state;

endmodule
`default_nettype wire
